instruction_fetch_unit: RTL and testbench
=========================================

// Module: instruction_fetch_unit
// PURPOSE
//   Fetch side of the multicycle core. Owns the PC and the instruction register (IR).
//   Serves the control unit's W_MI/W_PC/S_MXPC strobes: reads instruction memory over a REQ/ACK handshake.
//   Splits the IR into the type/op fields that the control unit decodes in ID.
// PARAMETERS
//   ADDR_W          16   PC / instruction-memory address width
//   RESET_PC        0    PC value loaded on reset
//   TIMEOUT_CYCLES  15   max cycles waiting for IM_ACK (only with FETCH_TIMEOUT_EN)
// PORTS
//   CLK        in   1       clock, rising edge
//   RST        in   1       asynchronous reset, active-high
//   W_MI       in   1       fetch strobe from control unit (level, sampled each CLK)
//   W_PC       in   1       PC write strobe
//   S_MXPC     in   1       PC source: 0 = PC+1, 1 = BR_TARGET
//   BR_TARGET  in   ADDR_W  branch/jump target address
//   IM_ADDR    out  ADDR_W  instruction-memory address (stable while IM_REQ=1)
//   IM_REQ     out  1       memory read request
//   IM_RDATA   in   32      memory read data, valid when IM_ACK=1
//   IM_ACK     in   1       memory read acknowledge
//   PC         out  ADDR_W  current program counter
//   INSTR      out  32      instruction register
//   type       out  3       INSTR[31:29]
//   op         out  5       INSTR[28:24]
//   IMM        out  16      INSTR[15:0]
//   INSTR_VLD  out  1       one-cycle pulse: IR just loaded
//   BUSY       out  1       fetch in flight (state != IDLE)
//   FETCH_ERR  out  1       sticky timeout flag (constant 0 without FETCH_TIMEOUT_EN)
// BEHAVIOUR
//   Reset (async, immediate): PC=RESET_PC, INSTR=0, IM_REQ=0, IM_ADDR=RESET_PC, INSTR_VLD=0, FETCH_ERR=0, state=IDLE.
//   FSM: IDLE -> WAIT on W_MI=1; WAIT -> IDLE on IM_ACK=1 (or on timeout); no other states.
//   IDLE, W_MI=1: next edge IM_ADDR<=PC, IM_REQ<=1, state<=WAIT.
//   WAIT: IM_REQ and IM_ADDR held; on IM_ACK=1 next edge INSTR<=IM_RDATA, IM_REQ<=0, INSTR_VLD<=1 (one cycle only).
//   type/op/IMM are combinational slices of INSTR: they change only when INSTR loads.
//   Latency: W_MI sampled at edge n -> IM_REQ=1 after n; ACK sampled at edge m -> INSTR valid after m.
//     Zero-wait memory (ACK combinational with REQ): W_MI to INSTR_VLD = 2 edges.
//   IM_ACK while IDLE: ignored, IR unchanged.
//   W_MI while WAIT: ignored, no queueing; W_MI held high through completion does not re-fetch
//     until one IDLE cycle sees W_MI=1 again (a re-fetch in that cycle is legal).
//   W_PC=1: next edge PC <= S_MXPC ? BR_TARGET : PC+1, in any state.
//     PC+1 wraps modulo 2^ADDR_W (all-ones -> 0).
//   W_PC during WAIT: PC updates; the in-flight IM_ADDR is unaffected; the fetched word still loads into IR.
//   W_PC and W_MI on the same IDLE edge: IM_ADDR takes the OLD PC; PC takes the new value.
//   RST mid-fetch: IM_REQ drops immediately; a later IM_ACK is ignored.
// CONFIGURATION
//   FETCH_TIMEOUT_EN defined:
//     - 4-bit-min counter runs in WAIT.
//     - After TIMEOUT_CYCLES cycles with no ACK: abort, INSTR<=0 (NOP), INSTR_VLD pulses, FETCH_ERR<=1 (sticky until RST).
//     - IM_REQ drops and state returns to IDLE.
//   FETCH_TIMEOUT_EN undefined: WAIT holds indefinitely; FETCH_ERR tied 0; no counter logic.
// TESTING
//   1. RST=1 then release; no strobes -> PC=0, IM_REQ=0, INSTR=0, INSTR_VLD=0 for 10 cycles.
//   2. Zero-wait memory, word 0x2A1F0005 at addr 0; pulse W_MI
//      -> IM_ADDR=0, INSTR=0x2A1F0005, type=3'b001, op=5'b01010, IMM=0x0005, one INSTR_VLD pulse.
//   3. ACK delayed 3 cycles; W_PC=1, S_MXPC=0 during WAIT
//      -> IM_ADDR stays 0 until ACK, PC=1, IR gets addr-0 word.
//   4. PC=0xFFFF, W_PC=1, S_MXPC=0 -> PC=0x0000.
//      Then W_PC=1, S_MXPC=1, BR_TARGET=0x1234 -> PC=0x1234.
//   5. W_MI held high 6 cycles with 1-wait memory -> exactly 2 fetches with one IDLE cycle between; extra W_MI ignored.
//   6. FETCH_TIMEOUT_EN, IM_ACK tied 0, W_MI pulse
//      -> after 15 WAIT cycles: IM_REQ=0, INSTR=0, INSTR_VLD pulse, FETCH_ERR=1 until RST.

Source files
------------

// File: rtl/instruction_fetch_unit.sv
// Fetch side of the multicycle core: owns PC and IR, reads instruction memory over IM_REQ/IM_ACK (optional FETCH_TIMEOUT_EN).
// Latency: W_MI sampled at edge n -> IM_REQ after n; IM_ACK sampled at edge m -> INSTR/INSTR_VLD after m.
// Backpressure: IM_REQ/IM_ADDR held until IM_ACK; W_MI seen during a fetch is dropped, not queued.
module instruction_fetch_unit #(
    parameter int                ADDR_W         = 16,
    parameter logic [ADDR_W-1:0] RESET_PC       = '0,
    parameter int                TIMEOUT_CYCLES = 15
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              W_MI,
    input  logic              W_PC,
    input  logic              S_MXPC,
    input  logic [ADDR_W-1:0] BR_TARGET,
    output logic [ADDR_W-1:0] IM_ADDR,
    output logic              IM_REQ,
    input  logic [31:0]       IM_RDATA,
    input  logic              IM_ACK,
    output logic [ADDR_W-1:0] PC,
    output logic [31:0]       INSTR,
    output logic [2:0]        TYPE,
    output logic [4:0]        op,
    output logic [15:0]       IMM,
    output logic              INSTR_VLD,
    output logic              BUSY,
    output logic              FETCH_ERR
);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] WAIT = 1'b1;

    logic [0:0] state;

`ifdef FETCH_TIMEOUT_EN
    localparam int CNT_W = ($clog2(TIMEOUT_CYCLES) > 4) ? $clog2(TIMEOUT_CYCLES) : 4;

    logic [CNT_W-1:0] wait_cnt;
    logic             timeout;

    // wait_cnt counts completed WAIT cycles; abort on the last one without ACK
    assign timeout = (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
    assign FETCH_ERR = 1'b0;
`endif

    assign TYPE = INSTR[31:29];
    assign op   = INSTR[28:24];
    assign IMM  = INSTR[15:0];
    assign BUSY = (state != IDLE);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state     <= IDLE;
            PC        <= RESET_PC;
            IM_ADDR   <= RESET_PC;
            IM_REQ    <= 1'b0;
            INSTR     <= '0;
            INSTR_VLD <= 1'b0;
`ifdef FETCH_TIMEOUT_EN
            wait_cnt  <= '0;
            FETCH_ERR <= 1'b0;
`endif
        end else begin
            INSTR_VLD <= 1'b0;
            // PC update is independent of the fetch; IM_ADDR already captured the old PC
            if (W_PC) begin
                PC <= S_MXPC ? BR_TARGET : PC + ADDR_W'(1);
            end
            case (state)
                IDLE: begin
                    if (W_MI) begin
                        IM_ADDR  <= PC;
                        IM_REQ   <= 1'b1;
                        state    <= WAIT;
`ifdef FETCH_TIMEOUT_EN
                        wait_cnt <= '0;
`endif
                    end
                end
                WAIT: begin
                    if (IM_ACK) begin
                        INSTR     <= IM_RDATA;
                        IM_REQ    <= 1'b0;
                        INSTR_VLD <= 1'b1;
                        state     <= IDLE;
                    end
`ifdef FETCH_TIMEOUT_EN
                    else if (timeout) begin
                        INSTR     <= '0;
                        IM_REQ    <= 1'b0;
                        INSTR_VLD <= 1'b1;
                        FETCH_ERR <= 1'b1;
                        state     <= IDLE;
                    end else begin
                        wait_cnt  <= wait_cnt + CNT_W'(1);
                    end
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit with a transaction-level reference model and per-cycle compare.
module tb_instruction_fetch_unit;

    localparam int TO_CYCLES = 15;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic        W_MI = 1'b0;
    logic        W_PC = 1'b0;
    logic        S_MXPC = 1'b0;
    logic [15:0] BR_TARGET = 16'h0;
    logic [15:0] IM_ADDR;
    logic        IM_REQ;
    logic [31:0] IM_RDATA;
    logic        IM_ACK;
    logic [15:0] PC;
    logic [31:0] INSTR;
    logic [2:0]  TYPE;
    logic [4:0]  op;
    logic [15:0] IMM;
    logic        INSTR_VLD;
    logic        BUSY;
    logic        FETCH_ERR;

    instruction_fetch_unit dut (
        .CLK(CLK), .RST(RST), .W_MI(W_MI), .W_PC(W_PC), .S_MXPC(S_MXPC),
        .BR_TARGET(BR_TARGET), .IM_ADDR(IM_ADDR), .IM_REQ(IM_REQ),
        .IM_RDATA(IM_RDATA), .IM_ACK(IM_ACK), .PC(PC), .INSTR(INSTR),
        .TYPE(TYPE), .op(op), .IMM(IMM), .INSTR_VLD(INSTR_VLD),
        .BUSY(BUSY), .FETCH_ERR(FETCH_ERR)
    );

    always #5 CLK = ~CLK;

    // Memory: ACK once the request has been outstanding wait_n cycles (0 = same cycle)
    logic [31:0] mem [256];
    int          wait_n = 0;
    int          req_age = 0;
    logic        ack_force = 1'b0;

    assign IM_RDATA = mem[IM_ADDR[7:0]];
    assign IM_ACK   = ack_force | (IM_REQ && (req_age >= wait_n));

    always @(posedge CLK) req_age <= (IM_REQ && !IM_ACK) ? req_age + 1 : 0;

    int tests = 0;
    int fails = 0;
    int vld_count = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: one outstanding fetch at a time, PC arithmetic mod 2^16
    logic [15:0] m_pc, m_addr;
    logic [31:0] m_instr;
    bit          m_busy, m_vld, m_err;
    int          m_age;
    logic        s_rst, s_wmi, s_wpc, s_mx, s_ack;
    logic [15:0] s_br, nxt_pc;

    always begin
        @(posedge CLK);
        s_rst = RST; s_wmi = W_MI; s_wpc = W_PC; s_mx = S_MXPC; s_br = BR_TARGET; s_ack = IM_ACK;
        #1;
        if (s_rst) begin
            m_pc = 16'h0; m_addr = 16'h0; m_instr = 32'h0;
            m_busy = 0; m_vld = 0; m_err = 0; m_age = 0;
        end else begin
            m_vld  = 0;
            nxt_pc = !s_wpc ? m_pc : (s_mx ? s_br : m_pc + 16'd1);
            if (m_busy) begin
                if (s_ack) begin
                    m_instr = mem[m_addr[7:0]];
                    m_vld = 1; m_busy = 0;
                end
`ifdef FETCH_TIMEOUT_EN
                else begin
                    m_age++;
                    if (m_age == TO_CYCLES) begin
                        m_instr = 32'h0; m_vld = 1; m_busy = 0; m_err = 1;
                    end
                end
`endif
            end else if (s_wmi) begin
                m_addr = m_pc; m_busy = 1; m_age = 0;
            end
            m_pc = nxt_pc;
        end
        chk("PC", {16'h0, PC}, {16'h0, m_pc});
        chk("IM_ADDR", {16'h0, IM_ADDR}, {16'h0, m_addr});
        chk("IM_REQ", {31'h0, IM_REQ}, {31'h0, m_busy});
        chk("BUSY", {31'h0, BUSY}, {31'h0, m_busy});
        chk("INSTR", INSTR, m_instr);
        chk("TYPE", {29'h0, TYPE}, {29'h0, m_instr[31:29]});
        chk("op", {27'h0, op}, {27'h0, m_instr[28:24]});
        chk("IMM", {16'h0, IMM}, {16'h0, m_instr[15:0]});
        chk("INSTR_VLD", {31'h0, INSTR_VLD}, {31'h0, m_vld});
        chk("FETCH_ERR", {31'h0, FETCH_ERR}, {31'h0, m_err});
        if (INSTR_VLD) vld_count++;
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic pulse_wmi();
        W_MI = 1'b1; cyc(1); W_MI = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'h1000_0000 + i * 32'h0101;
        mem[0] = 32'h2A1F_0005;

        // Reset and idle
        #1 RST = 1'b1;
        cyc(2); RST = 1'b0;
        cyc(10);
        chk("idle_pc", {16'h0, PC}, 32'h0);
        chk("idle_req", {31'h0, IM_REQ}, 32'h0);
        chk("idle_instr", INSTR, 32'h0);
        chk("idle_vld", {31'h0, INSTR_VLD}, 32'h0);

        // Zero-wait fetch from address 0
        wait_n = 0;
        pulse_wmi();
        chk("zw_addr", {16'h0, IM_ADDR}, 32'h0);
        chk("zw_req", {31'h0, IM_REQ}, 32'h1);
        cyc(1);
        chk("zw_vld", {31'h0, INSTR_VLD}, 32'h1);
        chk("zw_instr", INSTR, 32'h2A1F_0005);
        chk("zw_type", {29'h0, TYPE}, 32'h1);
        chk("zw_op", {27'h0, op}, 32'h0A);
        chk("zw_imm", {16'h0, IMM}, 32'h0005);
        cyc(1);
        chk("zw_vld_once", {31'h0, INSTR_VLD}, 32'h0);

        // Delayed ACK with PC increment during WAIT
        wait_n = 3;
        pulse_wmi();
        W_PC = 1'b1; S_MXPC = 1'b0;
        cyc(1); W_PC = 1'b0;
        chk("dly_pc", {16'h0, PC}, 32'h1);
        chk("dly_addr", {16'h0, IM_ADDR}, 32'h0);
        chk("dly_req", {31'h0, IM_REQ}, 32'h1);
        cyc(6);
        chk("dly_instr", INSTR, 32'h2A1F_0005);
        chk("dly_pc2", {16'h0, PC}, 32'h1);

        // PC wrap and branch target
        W_PC = 1'b1; S_MXPC = 1'b1; BR_TARGET = 16'hFFFF;
        cyc(1);
        chk("br_ffff", {16'h0, PC}, 32'hFFFF);
        S_MXPC = 1'b0;
        cyc(1);
        chk("wrap", {16'h0, PC}, 32'h0);
        S_MXPC = 1'b1; BR_TARGET = 16'h1234;
        cyc(1);
        chk("br_1234", {16'h0, PC}, 32'h1234);
        W_PC = 1'b0; S_MXPC = 1'b0;

        // W_PC and W_MI on the same idle edge: fetch uses the old PC
        wait_n = 0;
        W_MI = 1'b1; W_PC = 1'b1;
        cyc(1); W_MI = 1'b0; W_PC = 1'b0;
        chk("same_addr", {16'h0, IM_ADDR}, 32'h1234);
        chk("same_pc", {16'h0, PC}, 32'h1235);
        cyc(1);
        chk("same_instr", INSTR, 32'h1000_0000 + 32'h34 * 32'h0101);

        // ACK while idle is ignored
        ack_force = 1'b1;
        cyc(1); ack_force = 1'b0;
        chk("idle_ack_instr", INSTR, 32'h1000_0000 + 32'h34 * 32'h0101);
        chk("idle_ack_vld", {31'h0, INSTR_VLD}, 32'h0);

        // W_MI held 6 cycles, 1-wait memory: two fetches
        wait_n = 1;
        vld_count = 0;
        W_MI = 1'b1;
        cyc(6); W_MI = 1'b0;
        cyc(4);
        chk("hold_fetches", vld_count, 32'd2);

        // Reset mid-fetch drops the request immediately; late ACK ignored
        wait_n = 5;
        pulse_wmi();
        cyc(1);
        RST = 1'b1;
        #1;
        chk("rst_req", {31'h0, IM_REQ}, 32'h0);
        chk("rst_busy", {31'h0, BUSY}, 32'h0);
        cyc(1); RST = 1'b0;
        ack_force = 1'b1;
        cyc(1); ack_force = 1'b0;
        chk("rst_instr", INSTR, 32'h0);
        chk("rst_pc", {16'h0, PC}, 32'h0);

        // Unanswered fetch: timeout abort if enabled, otherwise waits indefinitely
        wait_n = 0;
        pulse_wmi();
        cyc(1);
        wait_n = 1000;
        pulse_wmi();
        cyc(20);
`ifdef FETCH_TIMEOUT_EN
        chk("to_req", {31'h0, IM_REQ}, 32'h0);
        chk("to_instr", INSTR, 32'h0);
        chk("to_err", {31'h0, FETCH_ERR}, 32'h1);
`else
        chk("to_req", {31'h0, IM_REQ}, 32'h1);
        chk("to_instr", INSTR, 32'h2A1F_0005);
        chk("to_err", {31'h0, FETCH_ERR}, 32'h0);
`endif
        wait_n = 0;
        cyc(3);
        pulse_wmi();
        cyc(2);
        chk("after_instr", INSTR, 32'h2A1F_0005);
`ifdef FETCH_TIMEOUT_EN
        chk("err_sticky", {31'h0, FETCH_ERR}, 32'h1);
`else
        chk("err_sticky", {31'h0, FETCH_ERR}, 32'h0);
`endif
        RST = 1'b1;
        cyc(1); RST = 1'b0;
        cyc(1);
        chk("err_cleared", {31'h0, FETCH_ERR}, 32'h0);

        cyc(2);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
